agc_gain_update: RTL and testbench

AGC_GAIN_UPDATE -- requirements
Module: agc_gain_update

---
 rtl/agc_gain_update.sv | 164 ++++++++++++++++
 tb/tb_agc_gain_update.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_update.sv
// ---------------------------------------------------------------------------
// agc_gain_update
//   Gain-update stage of an automatic gain control loop. Each accepted
//   accumulated level produces one first-order loop step:
//     err  = REF_LEVEL - level            (16-bit signed)
//     step = err >>> MU_SHIFT             (floor toward minus infinity)
//     gain = clamp(gain + step, GAIN_MIN, GAIN_MAX)
//   The update is spread over a four-state FSM (IDLE, CALC, SCALE, UPDATE),
//   so the new gain appears three cycles after the accepting edge.
//
// Optional feature (compile-time macro AGC_LOCK_DETECT_EN):
//   When defined, a saturating counter tracks consecutive updates with
//   |err| <= LOCK_TOL and o_locked is high while it is >= LOCK_CNT.
//   When undefined, no counter is built and o_locked is tied low.
//
// Ports
//   i_clk      in   1   clock, all state on the rising edge
//   i_rst      in   1   asynchronous active-high reset
//   i_valid    in   1   strobe: i_num carries a new accumulated level
//   i_num      in  15   unsigned accumulated level
//   o_gain     out 12   current gain, unsigned Q2.10, registered
//   o_valid    out  1   one-cycle pulse: o_gain just updated
//   o_busy     out  1   high while an update is in flight (state != IDLE)
//   o_overrun  out  1   one-cycle pulse: i_valid arrived while busy, dropped
//   o_locked   out  1   loop settled indicator
// ---------------------------------------------------------------------------
module agc_gain_update #(
  parameter logic [14:0] REF_LEVEL = 15'd8192,
  parameter int          MU_SHIFT  = 4,
  parameter logic [11:0] GAIN_INIT = 12'd1024,
  parameter logic [11:0] GAIN_MIN  = 12'd16,
  parameter logic [11:0] GAIN_MAX  = 12'd4095,
  parameter logic [14:0] LOCK_TOL  = 15'd256,
  parameter int          LOCK_CNT  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [14:0] i_num,
  output logic [11:0] o_gain,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_locked
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    SCALE  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t             r_state;
  logic [14:0]        r_level;
  logic signed [15:0] r_err;
  logic signed [15:0] r_step;
  logic [11:0]        r_gain;
  logic               r_valid;
  logic               r_overrun;

  logic signed [15:0] w_err;
  logic signed [16:0] w_sum;
  logic [11:0]        w_gain_next;

  // Both operands are 15-bit unsigned, so the 16-bit signed difference
  // cannot overflow.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    w_err       = $signed({1'b0, REF_LEVEL}) - $signed({1'b0, r_level});
    w_sum       = $signed({5'b0, r_gain}) + $signed({r_step[15], r_step});
    w_gain_next = w_sum[11:0];
    if (w_sum < $signed({5'b0, GAIN_MIN})) begin
      w_gain_next = GAIN_MIN;
    end else if (w_sum > $signed({5'b0, GAIN_MAX})) begin
      w_gain_next = GAIN_MAX;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_level   <= '0;
      r_err     <= '0;
      r_step    <= '0;
      r_gain    <= GAIN_INIT;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      // A strobe seen while an update is in flight is dropped and flagged;
      // the in-flight update carries on untouched.
      r_overrun <= i_valid && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_level <= i_num;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_err   <= w_err;
          r_state <= SCALE;
        end
        SCALE: begin
          r_step  <= r_err >>> MU_SHIFT;
          r_state <= UPDATE;
        end
        UPDATE: begin
          r_gain  <= w_gain_next;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AGC_LOCK_DETECT_EN
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_CNT);

  logic [CNT_W-1:0]   r_lock_cnt;
  logic               r_locked;
  logic signed [15:0] w_abs_err;
  logic               w_in_band;
  logic [CNT_W-1:0]   w_cnt_next;

  // r_err still holds this update's error while in UPDATE; its most
  // negative value is 8192-32767, so negation cannot overflow.
  always_comb begin
    w_abs_err  = r_err[15] ? -r_err : r_err;
    w_in_band  = w_abs_err <= $signed({1'b0, LOCK_TOL});
    w_cnt_next = '0;
    if (w_in_band) begin
      w_cnt_next = (r_lock_cnt == CNT_LIM) ? r_lock_cnt : r_lock_cnt + 1'b1;
    end
  end

  // Updated on the same edge as o_gain, so o_locked moves with o_valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (r_state == UPDATE) begin
      r_lock_cnt <= w_cnt_next;
      r_locked   <= w_cnt_next >= CNT_LIM;
    end
  end

  assign o_locked = r_locked;
`else
  assign o_locked = 1'b0;
`endif

  assign o_gain    = r_gain;
  assign o_valid   = r_valid;
  assign o_busy    = (r_state != IDLE);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_agc_gain_update.sv
// ---------------------------------------------------------------------------
// tb_agc_gain_update
//   Directed and randomized checks of agc_gain_update against an arithmetic
//   model of the gain loop (floor division, clamp, consecutive in-band count).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_agc_gain_update;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [14:0] i_num = '0;
  logic [11:0] o_gain;
  logic        o_valid;
  logic        o_busy;
  logic        o_overrun;
  logic        o_locked;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_gain = 1024;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  agc_gain_update dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (i_valid),
    .i_num     (i_num),
    .o_gain    (o_gain),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_overrun (o_overrun),
    .o_locked  (o_locked)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div16(input int x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  // Applies one update of the loop to the model.
  task automatic model_update(input int n);
    int err;
    int g;
    err = 8192 - n;
    g   = m_gain + floor_div16(err);
    if (g < 16)   g = 16;
    if (g > 4095) g = 4095;
    m_gain = g;
    if (err <= 256 && err >= -256) begin
      if (m_cnt < 4) m_cnt++;
    end else begin
      m_cnt = 0;
    end
  endtask

  function automatic int model_locked();
`ifdef AGC_LOCK_DETECT_EN
    return (m_cnt >= 4) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    m_gain = 1024;
    m_cnt  = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full update; checks busy in flight, no early o_valid, and the result.
  task automatic run_update(input string tag, input int n);
    @(negedge clk);
    i_valid = 1'b1;
    i_num   = 15'(n);
    @(negedge clk);
    i_valid = 1'b0;
    check({tag, "_busy"}, int'(o_busy), 1);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early_valid"}, int'(o_valid), 0);
    @(negedge clk);
    model_update(n);
    check({tag, "_valid"}, int'(o_valid), 1);
    check({tag, "_gain"}, int'(o_gain), m_gain);
    check({tag, "_locked"}, int'(o_locked), model_locked());
    check({tag, "_idle"}, int'(o_busy), 0);
  endtask

  initial begin
    int a;
    int b;
    int c;
    int gap;
    int n;

    // Reset state
    @(negedge clk);
    check("rst_gain", int'(o_gain), 1024);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_overrun", int'(o_overrun), 0);
    check("rst_locked", int'(o_locked), 0);
    do_reset();

    // Basic update: 4096 -> err 4096, step 256, gain 1280
    run_update("basic", 4096);
    check("basic_const", int'(o_gain), 1280);
    check("basic_overrun", int'(o_overrun), 0);
    @(negedge clk);
    check("basic_pulse_one", int'(o_valid), 0);

    // Lower clamp: 32767 -> step -1536
    do_reset();
    run_update("clamp_lo", 32767);
    check("clamp_lo_const", int'(o_gain), 16);

    // Upper clamp: repeated level 0 -> step +512 until 4095
    do_reset();
    for (int i = 0; i < 7; i++) run_update("clamp_hi", 0);
    check("clamp_hi_const", int'(o_gain), 4095);

    // Overrun and minimum spacing
    do_reset();
    a = int'($urandom_range(0, 32767));
    b = int'($urandom_range(0, 32767));
    c = int'($urandom_range(0, 32767));
    @(negedge clk);
    i_valid = 1'b1; i_num = 15'(a);
    @(negedge clk);
    i_valid = 1'b0;
    check("ovr_none", int'(o_overrun), 0);
    @(negedge clk);
    i_valid = 1'b1; i_num = 15'(b);
    @(negedge clk);
    i_valid = 1'b0;
    check("ovr_pulse", int'(o_overrun), 1);
    check("ovr_no_valid", int'(o_valid), 0);
    @(negedge clk);
    model_update(a);
    check("ovr_valid", int'(o_valid), 1);
    check("ovr_gain", int'(o_gain), m_gain);
    check("ovr_pulse_one", int'(o_overrun), 0);
    i_valid = 1'b1; i_num = 15'(c);
    @(negedge clk);
    i_valid = 1'b0;
    check("spacing_busy", int'(o_busy), 1);
    check("spacing_valid_low", int'(o_valid), 0);
    check("spacing_no_ovr", int'(o_overrun), 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    model_update(c);
    check("spacing_valid", int'(o_valid), 1);
    check("spacing_gain", int'(o_gain), m_gain);

    // Reset mid-update
    do_reset();
    run_update("pre_abort", 0);
    @(negedge clk);
    i_valid = 1'b1; i_num = 15'd0;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_gain", int'(o_gain), 1024);
    check("abort_busy", int'(o_busy), 0);
    check("abort_valid", int'(o_valid), 0);
    m_gain = 1024;
    m_cnt  = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_valid", int'(o_valid), 0);
    end
    run_update("post_abort", 4096);

    // Lock detection: four in-band updates, then an out-of-band one
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_update("lock_pre", 8192);
      check("lock_not_yet", int'(o_locked), 0);
    end
    run_update("lock_4th", 8192);
`ifdef AGC_LOCK_DETECT_EN
    check("lock_rise", int'(o_locked), 1);
`else
    check("lock_absent", int'(o_locked), 0);
`endif
    run_update("lock_fall", 0);
    check("lock_fell", int'(o_locked), 0);

    // Randomized levels with random idle gaps, biased to sometimes land in band
    do_reset();
    for (int i = 0; i < 30; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int k = 0; k < gap; k++) @(negedge clk);
      if ($urandom_range(0, 2) == 0) n = 8192 - 300 + int'($urandom_range(0, 600));
      else n = int'($urandom_range(0, 32767));
      run_update("rand", n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
